// File: rtl/bram_arb_pkg.sv
// Shared types, requester IDs and default widths for the BRAM arbiter.
package bram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic REQ_HOST  = 1'b0;
   localparam logic REQ_MINER = 1'b1;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_LANE_W    = 9;
   localparam int DEF_WDATA_W   = 32;
   localparam int DEF_RDATA_W   = 512;
   localparam int DEF_RD_LAT    = 1;
   localparam int DEF_MAX_BURST = 16;
   localparam int STAT_W        = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/bram_arb_rdtag.sv
// Read tag pipe: one {valid, owner} entry per strobe; stage 0 lines up with the
// strobe, stage RD_LAT lines up with bram_data_out so the data can be steered.
module bram_arb_rdtag #(
   parameter int RD_LAT = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic push_i,
   input  logic owner_i,
   output logic ret_vld_o,
   output logic ret_owner_o,
   output logic busy_o
);

   logic [RD_LAT:0] vld_q;
   logic [RD_LAT:0] own_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         own_q <= '0;
      end else begin
         vld_q <= {vld_q[RD_LAT-1:0], push_i};
         own_q <= {own_q[RD_LAT-1:0], owner_i};
      end
   end

   assign ret_vld_o   = vld_q[RD_LAT];
   assign ret_owner_o = own_q[RD_LAT];
   assign busy_o      = |vld_q;

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter between host loader (r0) and miner (r1) for the shared BRAM.
// Define ARB_STATS_EN to add saturating grant / wait counters.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int LANE_W    = DEF_LANE_W,
   parameter int WDATA_W   = DEF_WDATA_W,
   parameter int RDATA_W   = DEF_RDATA_W,
   parameter int RD_LAT    = DEF_RD_LAT,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               r0_req,
   input  logic               r0_we,
   input  logic [ADDR_W-1:0]  r0_addr,
   input  logic [LANE_W-1:0]  r0_lane,
   input  logic [WDATA_W-1:0] r0_wdata,
   input  logic               r0_last,
   input  logic               r1_req,
   input  logic               r1_we,
   input  logic [ADDR_W-1:0]  r1_addr,
   input  logic [LANE_W-1:0]  r1_lane,
   input  logic [WDATA_W-1:0] r1_wdata,
   input  logic               r1_last,
   output logic               r0_gnt,
   output logic               r1_gnt,
   output logic               r0_rvalid,
   output logic               r1_rvalid,
   output logic [RDATA_W-1:0] r0_rdata,
   output logic [RDATA_W-1:0] r1_rdata,
   output logic               cs_n,
   output logic               wr_n,
   output logic               rd_n,
   output logic [ADDR_W-1:0]  addr,
   output logic [LANE_W-1:0]  addr_width,
   output logic [WDATA_W-1:0] bram_data_in,
   input  logic [RDATA_W-1:0] bram_data_out,
   output logic               owner,
`ifdef ARB_STATS_EN
   output logic [STAT_W-1:0]  stat_gnt0,
   output logic [STAT_W-1:0]  stat_gnt1,
   output logic [STAT_W-1:0]  stat_wait,
`endif
   output logic               busy
);

   localparam int BEAT_W = $clog2(MAX_BURST + 1);

   arb_state_e         state_q;
   logic               r0_gnt_q, r1_gnt_q, owner_q, rr_q;
   logic [BEAT_W-1:0]  beat_q;
   logic               cs_n_q, wr_n_q, rd_n_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LANE_W-1:0]  lane_q;
   logic [WDATA_W-1:0] wdata_q;
   logic               r0_rvalid_q, r1_rvalid_q;
   logic [RDATA_W-1:0] r0_rdata_q, r1_rdata_q;

   logic               acc0_d, acc1_d, beat_d, beat_we_d, beat_last_d;
   logic [ADDR_W-1:0]  beat_addr_d;
   logic [LANE_W-1:0]  beat_lane_d;
   logic [WDATA_W-1:0] beat_wdata_d;
   logic               own_req_d, release_d, gnt0_d, gnt1_d;
   logic               tag_vld, tag_owner, tag_busy;

   // Only the owner's gnt is ever high, so the accepted beat is a simple mux.
   always_comb begin
      acc0_d       = r0_req & r0_gnt_q;
      acc1_d       = r1_req & r1_gnt_q;
      beat_d       = acc0_d | acc1_d;
      beat_we_d    = acc1_d ? r1_we    : r0_we;
      beat_last_d  = acc1_d ? r1_last  : r0_last;
      beat_addr_d  = acc1_d ? r1_addr  : r0_addr;
      beat_lane_d  = acc1_d ? r1_lane  : r0_lane;
      beat_wdata_d = acc1_d ? r1_wdata : r0_wdata;
      own_req_d    = (state_q == GNT1) ? r1_req : r0_req;
      release_d    = ~own_req_d |
                     (beat_d & (beat_last_d | (beat_q == BEAT_W'(MAX_BURST - 1))));
      gnt0_d       = (state_q == IDLE) & r0_req & (~r1_req | (rr_q == REQ_HOST));
      gnt1_d       = (state_q == IDLE) & r1_req & ~gnt0_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         r0_gnt_q <= 1'b0;
         r1_gnt_q <= 1'b0;
         owner_q  <= REQ_HOST;
         rr_q     <= REQ_HOST;
         beat_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0_d) begin
                  state_q  <= GNT0;
                  r0_gnt_q <= 1'b1;
                  owner_q  <= REQ_HOST;
                  rr_q     <= REQ_MINER;
               end else if (gnt1_d) begin
                  state_q  <= GNT1;
                  r1_gnt_q <= 1'b1;
                  owner_q  <= REQ_MINER;
                  rr_q     <= REQ_HOST;
               end
            end
            GNT0, GNT1: begin
               if (release_d) begin
                  state_q  <= IDLE;
                  r0_gnt_q <= 1'b0;
                  r1_gnt_q <= 1'b0;
                  beat_q   <= '0;
               end else if (beat_d) begin
                  beat_q <= beat_q + BEAT_W'(1);
               end
            end
            default: begin
               state_q  <= IDLE;
               r0_gnt_q <= 1'b0;
               r1_gnt_q <= 1'b0;
               beat_q   <= '0;
            end
         endcase
      end
   end

   // Address and data hold across idle cycles; only the strobes deassert.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         addr_q  <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
      end else if (beat_d) begin
         cs_n_q  <= 1'b0;
         wr_n_q  <= ~beat_we_d;
         rd_n_q  <= beat_we_d;
         addr_q  <= beat_addr_d;
         lane_q  <= beat_lane_d;
         wdata_q <= beat_wdata_d;
      end else begin
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
      end
   end

   bram_arb_rdtag #(
      .RD_LAT (RD_LAT)
   ) u_rdtag (
      .clock       (clock),
      .reset       (reset),
      .push_i      (beat_d & ~beat_we_d),
      .owner_i     (acc1_d),
      .ret_vld_o   (tag_vld),
      .ret_owner_o (tag_owner),
      .busy_o      (tag_busy)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         r0_rvalid_q <= tag_vld & (tag_owner == REQ_HOST);
         r1_rvalid_q <= tag_vld & (tag_owner == REQ_MINER);
         if (tag_vld && tag_owner == REQ_HOST)  r0_rdata_q <= bram_data_out;
         if (tag_vld && tag_owner == REQ_MINER) r1_rdata_q <= bram_data_out;
      end
   end

`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] stat_gnt0_q, stat_gnt1_q, stat_wait_q;
   logic              wait_d;

   assign wait_d = (r0_req & ~r0_gnt_q) | (r1_req & ~r1_gnt_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_gnt0_q <= '0;
         stat_gnt1_q <= '0;
         stat_wait_q <= '0;
      end else begin
         if (gnt0_d) stat_gnt0_q <= sat_inc(stat_gnt0_q);
         if (gnt1_d) stat_gnt1_q <= sat_inc(stat_gnt1_q);
         if (wait_d) stat_wait_q <= sat_inc(stat_wait_q);
      end
   end

   assign stat_gnt0 = stat_gnt0_q;
   assign stat_gnt1 = stat_gnt1_q;
   assign stat_wait = stat_wait_q;
`endif

   assign r0_gnt       = r0_gnt_q;
   assign r1_gnt       = r1_gnt_q;
   assign r0_rvalid    = r0_rvalid_q;
   assign r1_rvalid    = r1_rvalid_q;
   assign r0_rdata     = r0_rdata_q;
   assign r1_rdata     = r1_rdata_q;
   assign cs_n         = cs_n_q;
   assign wr_n         = wr_n_q;
   assign rd_n         = rd_n_q;
   assign addr         = addr_q;
   assign addr_width   = lane_q;
   assign bram_data_in = wdata_q;
   assign owner        = owner_q;
   assign busy         = r0_gnt_q | r1_gnt_q | tag_busy;

endmodule
